serial_adder_arbiter: RTL
=========================

# serial_adder_arbiter

Shares one bit-serial full-adder datapath between two requesters. Each requester presents a pair of WIDTH-bit operands on a req/gnt handshake. A round-robin arbiter picks one requester and captures its operands. An FSM then sequences the single full-adder slice over WIDTH cycles, LSB first. The block returns a WIDTH-bit sum, a carry-out and the requester id, and replaces a WIDTH-slice ripple adder where area matters more than latency.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held high until gnt0.
- a0  in  WIDTH  requester 0 operand A; stable while req0 high.
- b0  in  WIDTH  requester 0 operand B; stable while req0 high.
- req1  in  1  requester 1 request.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- gnt0  out  1  one-cycle pulse: requester 0 operands captured.
- gnt1  out  1  one-cycle pulse: requester 1 operands captured.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse: result valid.
- done_id  out  1  requester that owns the current result.
- sum  out  WIDTH  (A+B) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE and DONE both arbitrate.
  - RUN ignores requests.
- Arbitration happens in IDLE or DONE, at each rising edge where req0|req1 is high:
  - Only one req high: that requester wins.
  - Both high: the winner is the requester not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - At the capture edge:
    - Winner operands load into shift registers a_sh and b_sh.
    - Carry flop clears to 0.
    - Bit counter clears to 0.
    - id register takes the winner.
    - Last-served pointer updates to the winner.
    - Winner's gnt goes high for the following cycle.
    - State goes to RUN.
- RUN, each edge:
  - Full-adder slice computes s = a_sh[0]^b_sh[0]^c and c' = majority(a_sh[0], b_sh[0], c).
  - s shifts into the sum shift register at the MSB end; after WIDTH shifts, bit 0 sits at the LSB.
  - a_sh and b_sh shift right.
  - c <= c'.
  - Counter increments.
- At the edge where the counter equals WIDTH-1:
  - The last bit is processed.
  - sum, cout (= c') and done_id update.
  - State goes to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state is RUN if a request is captured at this edge, else IDLE.
- sum, cout and done_id hold their value until the next done. They do not change during RUN.
- A requester may drop req before being granted (withdraw); nothing is captured for it.
- Requests with req low never receive a gnt.
- No carry-in. Overflow is reported only through cout; sum wraps modulo 2^WIDTH.

## Timing
- Reset (asynchronous assert, any time):
  - State = IDLE, counter = 0, last-served pointer = 1.
  - gnt0 = gnt1 = busy = done = done_id = cout = 0; sum = 0.
  - Reset during RUN aborts the operation: no done and no gnt are produced for it.
  - First capture is possible at the first rising edge after rst_n deasserts.
- Capture at edge E0:
  - gnt high and busy high during cycle E0..E1.
  - busy stays high through cycle E(WIDTH-1)..E(WIDTH).
- At edge E(WIDTH): result registers update and done goes high during cycle E(WIDTH)..E(WIDTH+1).
- Latency from capture edge to done: WIDTH cycles.
- Back-to-back: the next capture can occur at E(WIDTH+1), which is the DONE-state edge.
  - done and the new gnt are never high in the same cycle.
  - busy is low during the DONE cycle.
  - Sustained throughput: one add per WIDTH+1 cycles.
- gnt0 and gnt1 are never high together. done is never high while busy is high.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset, then req0 with a0=3, b0=5 held (WIDTH=4) -> gnt0 pulse one cycle after capture; done 4 cycles after capture with sum=8, cout=0, done_id=0.
- req1 with a1=15, b1=1 -> sum=0, cout=1, done_id=1; then a1=9, b1=9 -> sum=2, cout=1.
- req0 and req1 both high from reset with distinct operands and held -> order 0, 1, 0, 1; captures 5 cycles apart; each done_id and sum matches the captured pair; gnt0 and gnt1 never overlap.
- req1 raised during RUN for requester 0 -> no gnt1 until the DONE edge; gnt1 in the cycle after done; busy low exactly one cycle between operations.
- rst_n pulsed low 2 cycles into RUN -> all outputs 0 immediately; no done afterwards; next req0 is granted and produces a correct sum.
- req0 raised for 1 cycle while busy, then dropped -> no gnt0, no extra done; sum and done_id retain the previous result.

Source files
------------

// File: rtl/serial_adder_arbiter.sv
// rtl/serial_adder_arbiter.sv - two-requester round-robin front end on a shared bit-serial adder
//
// Purpose:
//    Two requesters share one full-adder slice. A round-robin arbiter captures
//    the winner's operands, then the slice runs WIDTH cycles, LSB first. The
//    result is held until the next done pulse.
//
// Ports:
//    clk      in   rising-edge clock
//    rst_n    in   asynchronous active-low reset
//    req0     in   requester 0 request, held until gnt0
//    a0, b0   in   requester 0 operands, stable while req0 high
//    req1     in   requester 1 request, held until gnt1
//    a1, b1   in   requester 1 operands, stable while req1 high
//    gnt0     out  one-cycle pulse, requester 0 operands captured
//    gnt1     out  one-cycle pulse, requester 1 operands captured
//    busy     out  high while the serial add is running
//    done     out  one-cycle pulse, result valid
//    done_id  out  requester that owns the current result
//    sum      out  (A+B) mod 2^WIDTH
//    cout     out  carry out of bit WIDTH-1

module serial_adder_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the WIDTH-1 sum bits produced so far, newest at the MSB; the last
   // bit is merged in directly when the result register loads.
   logic [WIDTH-2:0] s_sh;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             id;
   logic             last;     // requester served most recently

   logic             arb_en;
   logic             win1;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;
   logic [WIDTH-1:0] s_cat;

   always_comb begin
      arb_en   = (state != S_RUN) && (req0 || req1);
      // On a tie, requester 1 wins only if requester 0 was served last.
      win1     = req1 && (!req0 || !last);
      fa_s     = a_sh[0] ^ b_sh[0] ^ c;
      fa_c     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
      last_bit = (cnt == CW'(WIDTH - 1));
      s_cat    = {fa_s, s_sh};
   end

   assign busy = (state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         id      <= 1'b0;
         last    <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (arb_en) begin
                  a_sh  <= win1 ? a1 : a0;
                  b_sh  <= win1 ? b1 : b0;
                  c     <= 1'b0;
                  cnt   <= '0;
                  id    <= win1;
                  last  <= win1;
                  gnt0  <= !win1;
                  gnt1  <= win1;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               s_sh <= s_cat[WIDTH-1:1];
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               c    <= fa_c;
               cnt  <= cnt + 1'b1;
               if (last_bit) begin
                  sum     <= s_cat;
                  cout    <= fa_c;
                  done_id <= id;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
